// File: rtl/fifo_tx_arb.sv
// fifo_tx_arb: two-requester round-robin packet arbiter feeding a shared FIFO,
// plus an independent drain engine that hands FIFO bytes one at a time to a
// UART transmitter. A grant is held for a whole packet (until a byte with
// iLast is accepted) or until the owner stays silent for pTimeout cycles.

module fifo_tx_arb #(
    parameter int pTimeout = 255  // owner-silent cycles before revoke, 1..255
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iReq0,
    input  logic       iReq1,
    input  logic [7:0] iData0,
    input  logic [7:0] iData1,
    input  logic       iLast0,
    input  logic       iLast1,
    output logic       oAck0,
    output logic       oAck1,
    input  logic       iFull,
    output logic       oPush,
    output logic [7:0] oWrData,
    input  logic       iEmpty,
    input  logic [7:0] iRdData,
    output logic       oPop,
    input  logic       iTxBusy,
    output logic       oTxStart,
    output logic [7:0] oTxData,
    output logic       oTimeout
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_GNT0,
        W_GNT1
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_WAITHI,
        R_WAITLO
    } r_state_t;

    // Counter value at which one more silent cycle revokes the grant.
    localparam logic [7:0] IDLE_LIMIT = 8'(pTimeout - 1);

    w_state_t   w_state;
    r_state_t   r_state;
    logic       last_served;  // 0: requester 0 served last, 1: requester 1
    logic [7:0] idle_cnt;
    logic       own_req;
    logic       own_last;

    // Owner-side write path: steer the granted requester onto the FIFO port.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
        own_req  = 1'b0;
        own_last = 1'b0;
        oAck0    = 1'b0;
        oAck1    = 1'b0;
        oWrData  = 8'h00;
        case (w_state)
            W_GNT0: begin
                own_req  = iReq0;
                own_last = iLast0;
                oAck0    = iReq0 & ~iFull;
                oWrData  = iData0;
            end
            W_GNT1: begin
                own_req  = iReq1;
                own_last = iLast1;
                oAck1    = iReq1 & ~iFull;
                oWrData  = iData1;
            end
            default: ;
        endcase
        oPush = oAck0 | oAck1;
    end

    // Write FSM: grant, packet ownership, idle timeout and round-robin pointer.
    always_ff @(posedge iClk or posedge iRst) begin
        // NOTE: state registers use non-blocking assignments so every branch reads pre-edge values.
        if (iRst) begin
            w_state     <= W_IDLE;
            last_served <= 1'b1;
            idle_cnt    <= 8'd0;
            oTimeout    <= 1'b0;
        end else begin
            oTimeout <= 1'b0;
            case (w_state)
                W_IDLE: begin
                    idle_cnt <= 8'd0;
                    if (iReq0 && iReq1) begin
                        w_state <= last_served ? W_GNT0 : W_GNT1;
                    end else if (iReq0) begin
                        w_state <= W_GNT0;
                    end else if (iReq1) begin
                        w_state <= W_GNT1;
                    end
                end
                W_GNT0, W_GNT1: begin
                    if (oPush) begin
                        idle_cnt <= 8'd0;
                        if (own_last) begin
                            w_state     <= W_IDLE;
                            last_served <= (w_state == W_GNT1);
                        end
                    end else if (!own_req) begin
                        if (idle_cnt == IDLE_LIMIT) begin
                            w_state     <= W_IDLE;
                            last_served <= (w_state == W_GNT1);
                            idle_cnt    <= 8'd0;
                            oTimeout    <= 1'b1;
                        end else begin
                            idle_cnt <= idle_cnt + 8'd1;
                        end
                    end
                    // A stalled owner (request held while FIFO full) keeps the
                    // grant and does not age toward the timeout.
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Pop only from the idle drain state; reset masks it so a pending FIFO
    // byte cannot be consumed while the block is held in reset.
    assign oPop = (r_state == R_IDLE) & ~iEmpty & ~iTxBusy & ~iRst;

    // Drain FSM: pop one byte, pulse start, then wait out a full busy cycle.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state  <= R_IDLE;
            oTxStart <= 1'b0;
            oTxData  <= 8'h00;
        end else begin
            oTxStart <= 1'b0;
            case (r_state)
                R_IDLE: begin
                    if (oPop) begin
                        oTxData  <= iRdData;
                        oTxStart <= 1'b1;
                        r_state  <= R_START;
                    end
                end
                R_START: r_state <= R_WAITHI;
                R_WAITHI: begin
                    if (iTxBusy) begin
                        r_state <= R_WAITLO;
                    end
                end
                R_WAITLO: begin
                    if (!iTxBusy) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_tx_arb.sv
// tb_fifo_tx_arb: directed vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.

module tb_fifo_tx_arb;

    localparam int TOUT = 4;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iReq0, iReq1;
    logic [7:0] iData0, iData1;
    logic       iLast0, iLast1;
    logic       oAck0, oAck1;
    logic       iFull;
    logic       oPush;
    logic [7:0] oWrData;
    logic       iEmpty;
    logic [7:0] iRdData;
    logic       oPop;
    logic       iTxBusy;
    logic       oTxStart;
    logic [7:0] oTxData;
    logic       oTimeout;

    fifo_tx_arb #(.pTimeout(TOUT)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iReq0    (iReq0),
        .iReq1    (iReq1),
        .iData0   (iData0),
        .iData1   (iData1),
        .iLast0   (iLast0),
        .iLast1   (iLast1),
        .oAck0    (oAck0),
        .oAck1    (oAck1),
        .iFull    (iFull),
        .oPush    (oPush),
        .oWrData  (oWrData),
        .iEmpty   (iEmpty),
        .iRdData  (iRdData),
        .oPop     (oPop),
        .iTxBusy  (iTxBusy),
        .oTxStart (oTxStart),
        .oTxData  (oTxData),
        .oTimeout (oTimeout)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iReq0 = 1'b0; iReq1 = 1'b0;
        iData0 = 8'h00; iData1 = 8'h00;
        iLast0 = 1'b0; iLast1 = 1'b0;
        iFull = 1'b0; iEmpty = 1'b1; iRdData = 8'h00; iTxBusy = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {7'b0, oAck0}, 8'h00);
        check(name, {7'b0, oAck1}, 8'h00);
        check(name, {7'b0, oPush}, 8'h00);
        check(name, oWrData, 8'h00);
        check(name, {7'b0, oPop}, 8'h00);
        check(name, {7'b0, oTxStart}, 8'h00);
        check(name, oTxData, 8'h00);
        check(name, {7'b0, oTimeout}, 8'h00);
    endtask

    task automatic do_reset();
        idle_inputs();
        iRst = 1'b1;
        #1;
        check_all_zero("reset_outputs");
        tick();
        iRst = 1'b0;
    endtask

    // Write-side expectations for the current cycle.
    task automatic expect_w(input string name, input logic a0, input logic a1,
                            input logic [7:0] wr, input logic to);
        check(name, {7'b0, oAck0}, {7'b0, a0});
        check(name, {7'b0, oAck1}, {7'b0, a1});
        check(name, {7'b0, oPush}, {7'b0, a0 | a1});
        check(name, oWrData, wr);
        check(name, {7'b0, oTimeout}, {7'b0, to});
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rq0, rq1;
        logic [7:0] d0, d1;
        logic       l0, l1, full;
        logic       e_ack0, e_ack1;
        logic [7:0] e_wr;
    } vec_t;

    vec_t tbl[12];

    // ---------------- reference model ----------------
    int         m_owner;   // -1: nobody holds the FIFO, else requester index
    int         m_prev;    // requester that finished most recently
    int         m_idle;    // silent owner cycles since last progress
    bit         m_tout;
    logic [7:0] m_txdata;
    bit         m_start_due, m_wait_busy, m_wait_free;

    task automatic model_reset();
        m_owner = -1; m_prev = 1; m_idle = 0; m_tout = 1'b0;
        m_txdata = 8'h00;
        m_start_due = 1'b0; m_wait_busy = 1'b0; m_wait_free = 1'b0;
    endtask

    task automatic model_step(input bit acked, input bit popped);
        bit req_n, last_n;
        if (m_owner < 0) begin
            m_tout = 1'b0;
            m_idle = 0;
            if (iReq0 && iReq1) m_owner = (m_prev == 1) ? 0 : 1;
            else if (iReq0)     m_owner = 0;
            else if (iReq1)     m_owner = 1;
        end else begin
            req_n  = (m_owner == 0) ? iReq0 : iReq1;
            last_n = (m_owner == 0) ? iLast0 : iLast1;
            m_tout = 1'b0;
            if (acked) begin
                m_idle = 0;
                if (last_n) begin
                    m_prev  = m_owner;
                    m_owner = -1;
                end
            end else if (!req_n) begin
                m_idle++;
                if (m_idle == TOUT) begin
                    m_prev  = m_owner;
                    m_owner = -1;
                    m_idle  = 0;
                    m_tout  = 1'b1;
                end
            end
        end
        // One byte at a time: start, see busy rise, see busy fall.
        if (m_start_due) begin
            m_start_due = 1'b0;
            m_wait_busy = 1'b1;
        end else if (m_wait_busy) begin
            if (iTxBusy) begin
                m_wait_busy = 1'b0;
                m_wait_free = 1'b1;
            end
        end else if (m_wait_free) begin
            if (!iTxBusy) m_wait_free = 1'b0;
        end else if (popped) begin
            m_txdata    = iRdData;
            m_start_due = 1'b1;
        end
    endtask

    initial begin
        byte unsigned fifo_q[$];
        int pop_cyc[$];
        int start_cyc[$];
        int busy_cnt;
        bit saw_pop, saw_start;
        bit e_ack0, e_ack1, e_pop;
        logic [7:0] e_wr;
        int p;

        tbl[0]  = '{1'b1, 1'b1, 8'hA0, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b1, 8'hA0, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0};
        tbl[2]  = '{1'b1, 1'b1, 8'hA1, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA1};
        tbl[3]  = '{1'b1, 1'b1, 8'hA2, 8'hB0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA2};
        tbl[4]  = '{1'b1, 1'b1, 8'hC0, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b1, 1'b1, 8'hC0, 8'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB0};
        tbl[6]  = '{1'b1, 1'b1, 8'hC0, 8'hB1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hB1};
        tbl[7]  = '{1'b1, 1'b1, 8'hC0, 8'hB1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hB1};
        tbl[8]  = '{1'b1, 1'b1, 8'hC0, 8'hB2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hB2};
        tbl[9]  = '{1'b1, 1'b1, 8'hC0, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[10] = '{1'b1, 1'b1, 8'hC0, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

        idle_inputs();
        iRst = 1'b0;
        tick();
        do_reset();

        // Round-robin packets: both requesting, 3-byte packets, one full stall.
        foreach (tbl[i]) begin
            iReq0 = tbl[i].rq0; iReq1 = tbl[i].rq1;
            iData0 = tbl[i].d0; iData1 = tbl[i].d1;
            iLast0 = tbl[i].l0; iLast1 = tbl[i].l1;
            iFull = tbl[i].full;
            #1;
            expect_w("table", tbl[i].e_ack0, tbl[i].e_ack1, tbl[i].e_wr, 1'b0);
            check("table_pop", {7'b0, oPop}, 8'h00);
            tick();
        end

        // Full FIFO stalls the owner without aging it; the other side waits.
        do_reset();
        iReq0 = 1'b1; iData0 = 8'h10;
        #1; expect_w("full_grant", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        #1; expect_w("full_byte1", 1'b1, 1'b0, 8'h10, 1'b0);
        tick();
        iFull = 1'b1; iReq1 = 1'b1; iData0 = 8'h11; iData1 = 8'h90; iLast0 = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1; expect_w("full_hold", 1'b0, 1'b0, 8'h11, 1'b0);
            tick();
        end
        iFull = 1'b0;
        #1; expect_w("full_resume", 1'b1, 1'b0, 8'h11, 1'b0);
        tick();
        iReq0 = 1'b0; iLast0 = 1'b0;
        #1; expect_w("full_idle", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        #1; expect_w("full_other", 1'b0, 1'b1, 8'h90, 1'b0);
        tick();

        // Silent owner is revoked after exactly TOUT idle cycles.
        do_reset();
        iReq0 = 1'b1; iData0 = 8'h20;
        #1; expect_w("tout_grant", 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        #1; expect_w("tout_byte1", 1'b1, 1'b0, 8'h20, 1'b0);
        tick();
        iReq0 = 1'b0; iReq1 = 1'b1; iData1 = 8'h77;
        for (int c = 0; c < TOUT; c++) begin
            #1; expect_w("tout_wait", 1'b0, 1'b0, 8'h20, 1'b0);
            tick();
        end
        #1; expect_w("tout_pulse", 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        #1; expect_w("tout_regrant", 1'b0, 1'b1, 8'h77, 1'b0);
        tick();

        // Drain: two bytes, UART busy 5 cycles after each start.
        do_reset();
        fifo_q = '{8'h41, 8'h42};
        busy_cnt = 0;
        for (int c = 0; c < 24; c++) begin
            iEmpty  = (fifo_q.size() == 0);
            iRdData = iEmpty ? 8'h00 : fifo_q[0];
            iTxBusy = (busy_cnt > 0);
            #1;
            saw_pop = oPop;
            saw_start = oTxStart;
            if (saw_pop) begin
                pop_cyc.push_back(c);
                check("drain_pop_nonempty", {7'b0, iEmpty}, 8'h00);
            end
            if (saw_start) start_cyc.push_back(c);
            if (c == 1) check("drain_data1", oTxData, 8'h41);
            if (c == 8) check("drain_hold1", oTxData, 8'h41);
            if (c == 9) check("drain_data2", oTxData, 8'h42);
            if (c == 20) check("drain_hold2", oTxData, 8'h42);
            tick();
            if (saw_pop) void'(fifo_q.pop_front());
            if (saw_start) busy_cnt = 5;
            else if (busy_cnt > 0) busy_cnt--;
        end
        check("drain_pop_count", 8'(pop_cyc.size()), 8'd2);
        check("drain_start_count", 8'(start_cyc.size()), 8'd2);
        while (pop_cyc.size() < 2) pop_cyc.push_back(99);
        while (start_cyc.size() < 2) start_cyc.push_back(99);
        check("drain_pop0_cycle", 8'(pop_cyc[0]), 8'd0);
        check("drain_start0_cycle", 8'(start_cyc[0]), 8'd1);
        check("drain_pop1_cycle", 8'(pop_cyc[1]), 8'd8);
        check("drain_start1_cycle", 8'(start_cyc[1]), 8'd9);

        // Reset mid-packet and mid-transmit.
        do_reset();
        iReq0 = 1'b1; iData0 = 8'h21; iEmpty = 1'b0; iRdData = 8'h55;
        #1;
        check("rst_pop", {7'b0, oPop}, 8'h01);
        tick();
        iEmpty = 1'b1;
        #1;
        expect_w("rst_byte1", 1'b1, 1'b0, 8'h21, 1'b0);
        check("rst_start", {7'b0, oTxStart}, 8'h01);
        check("rst_txdata", oTxData, 8'h55);
        tick();
        iFull = 1'b1;
        #1; expect_w("rst_stall", 1'b0, 1'b0, 8'h21, 1'b0);
        tick();
        iFull = 1'b0; iEmpty = 1'b0; iRst = 1'b1;
        #1; check_all_zero("rst_mid");
        tick();
        check_all_zero("rst_held");
        iRst = 1'b0; iReq0 = 1'b0; iReq1 = 1'b1; iData1 = 8'h66; iEmpty = 1'b1;
        #1;
        expect_w("rst_after_idle", 1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_after_nostart", {7'b0, oTxStart}, 8'h00);
        tick();
        #1;
        expect_w("rst_after_grant", 1'b0, 1'b1, 8'h66, 1'b0);
        check("rst_after_nopop", {7'b0, oPop}, 8'h00);
        tick();

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            case ((c / 200) % 3)
                0:       p = 30;
                1:       p = 65;
                default: p = 92;
            endcase
            iRst    = ($urandom_range(0, 127) == 0);
            iReq0   = ($urandom_range(0, 99) < p);
            iReq1   = ($urandom_range(0, 99) < p);
            iData0  = 8'($urandom);
            iData1  = 8'($urandom);
            iLast0  = ($urandom_range(0, 3) == 0);
            iLast1  = ($urandom_range(0, 3) == 0);
            iFull   = ($urandom_range(0, 3) == 0);
            iEmpty  = ($urandom_range(0, 1) == 0);
            iRdData = 8'($urandom);
            iTxBusy = ($urandom_range(0, 2) == 0);
            if (iRst) model_reset();
            e_ack0 = !iRst && m_owner == 0 && iReq0 && !iFull;
            e_ack1 = !iRst && m_owner == 1 && iReq1 && !iFull;
            e_wr   = (m_owner == 0) ? iData0 : (m_owner == 1) ? iData1 : 8'h00;
            e_pop  = !iRst && !(m_start_due || m_wait_busy || m_wait_free) && !iEmpty && !iTxBusy;
            #1;
            check("rnd_ack0", {7'b0, oAck0}, {7'b0, e_ack0});
            check("rnd_ack1", {7'b0, oAck1}, {7'b0, e_ack1});
            check("rnd_push", {7'b0, oPush}, {7'b0, e_ack0 | e_ack1});
            check("rnd_wrdata", oWrData, e_wr);
            check("rnd_timeout", {7'b0, oTimeout}, {7'b0, m_tout});
            check("rnd_pop", {7'b0, oPop}, {7'b0, e_pop});
            check("rnd_txstart", {7'b0, oTxStart}, {7'b0, m_start_due});
            check("rnd_txdata", oTxData, m_txdata);
            if (!iRst) model_step(e_ack0 | e_ack1, e_pop);
            tick();
        end
        iRst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
